// File: rtl/pipe_arith_pkg.sv
// Shared types and the operand arithmetic for the pipelined arithmetic unit.
// arith_compute works at MAX_WIDTH bits and masks down to the caller's width.
package pipe_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 ovf;
        logic [MAX_WIDTH-1:0] result;
        logic [MAX_WIDTH-1:0] acc_next;
    } arith_res_t;

    // ACC reuses the ADD datapath with the accumulator standing in for b.
    function automatic arith_res_t arith_compute(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic [MAX_WIDTH-1:0] acc,
        input op_e                  op,
        input logic                 saturate,
        input int                   width
    );
        arith_res_t           r;
        logic [MAX_WIDTH:0]   sum;
        logic [MAX_WIDTH:0]   carry;
        logic [MAX_WIDTH-1:0] ones;
        logic [MAX_WIDTH-1:0] addend;

        ones     = '1;
        ones     = ones >> (MAX_WIDTH - width);
        r.ovf    = 1'b0;
        r.result = '0;
        r.acc_next = acc;
        addend   = (op == OP_ACC) ? acc : b;
        sum      = {1'b0, a & ones} + {1'b0, addend & ones};
        carry    = sum >> width;

        case (op)
            OP_ADD, OP_ACC: begin
                r.ovf    = carry[0];
                r.result = sum[MAX_WIDTH-1:0] & ones;
                if (saturate && r.ovf) begin
                    r.result = ones;
                end
                if (op == OP_ACC) begin
                    r.acc_next = r.result;
                end
            end
            OP_SUB: begin
                r.ovf    = (a & ones) < (b & ones);
                r.result = (a - b) & ones;
                if (saturate && r.ovf) begin
                    r.result = '0;
                end
            end
            default: begin
                r.acc_next = '0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the result pipeline: a valid bit plus {data, ovf}.
// Loads whenever it is empty or its successor is taking the current beat.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;

    assign in_ready  = ena && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;

    // Payload is only overwritten by a real beat so a bubble keeps the last result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
                ovf_q  <= in_ovf;
            end
        end
    end

endmodule

// File: rtl/pipe_arith_unit.sv
// Pipelined add/sub/accumulate unit with valid/ready on both sides and a global freeze.
// The accumulator lives here and advances only on an accepted beat.
module pipe_arith_unit
    import pipe_arith_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] calc_data;
    logic [WIDTH-1:0] acc_next;
    logic             calc_ovf;
    logic             accept;
    arith_res_t       res;

    always_comb begin
        res       = arith_compute(MAX_WIDTH'(a), MAX_WIDTH'(b), MAX_WIDTH'(acc_q),
                                  op_e'(op), SATURATE, WIDTH);
        calc_data = res.result[WIDTH-1:0];
        acc_next  = res.acc_next[WIDTH-1:0];
        calc_ovf  = res.ovf;
    end

    if (WIDTH < MAX_WIDTH) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{res.result[MAX_WIDTH-1:WIDTH], res.acc_next[MAX_WIDTH-1:WIDTH]};
    end

    assign in_ready = !rst && g_stage[0].up_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_next;
        end
    end

    // Per-stage nets keep the ready chain in separate signals rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic             up_ready;
        logic [WIDTH-1:0] up_data;
        logic             up_ovf;
        logic             dn_valid;
        logic             dn_ready;
        logic [WIDTH-1:0] dn_data;
        logic             dn_ovf;

        if (i == 0) begin : g_head
            assign up_valid = accept;
            assign up_data  = calc_data;
            assign up_ovf   = calc_ovf;
        end else begin : g_link
            assign up_valid = g_stage[i-1].dn_valid;
            assign up_data  = g_stage[i-1].dn_data;
            assign up_ovf   = g_stage[i-1].dn_ovf;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_next
            assign dn_ready = g_stage[i+1].up_ready;
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .ena       (ena),
            .in_valid  (up_valid),
            .in_ready  (up_ready),
            .in_data   (up_data),
            .in_ovf    (up_ovf),
            .out_valid (dn_valid),
            .out_ready (dn_ready),
            .out_data  (dn_data),
            .out_ovf   (dn_ovf)
        );
    end

    assign out_valid = ena && g_stage[DEPTH-1].dn_valid;
    assign dout      = g_stage[DEPTH-1].dn_data;
    assign ovf       = g_stage[DEPTH-1].dn_ovf;

endmodule
